time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Input-side counterpart of the multiplexed clock display: turns the two raw push-buttons into clean set-time commands.
//  Conditions (sync + debounce) MODE and ADJ buttons, runs the RUN/SET_HOUR/SET_MIN mode FSM, emits 1-cycle
//  hour/minute increment pulses to the timekeeper and a digit blink mask to the display scanner.
// PARAMETERS
//  CLK_HZ       16000000  input clock frequency; all *_MS/*_S values are converted with it at elaboration
//  DEBOUNCE_MS  10        raw input must be stable this long before the debounced level changes
//  LONG_MS      1000      ADJ hold time before auto-repeat starts (AUTO_REPEAT_EN only)
//  REPEAT_MS    200       auto-repeat pulse interval (AUTO_REPEAT_EN only)
//  BLINK_MS     500       blink_on half-period in SET modes
//  TIMEOUT_S    30        inactivity time in a SET mode before forced return to RUN
// PORTS
//  CLK          in   1  system clock, single domain
//  RST          in   1  synchronous, active-high reset
//  btn_mode_raw in   1  raw MODE button, asynchronous, high = pressed
//  btn_adj_raw  in   1  raw ADJ button, asynchronous, high = pressed
//  mode         out  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN (3 never driven)
//  hour_inc     out  1  1-cycle pulse: advance hour by one
//  min_inc      out  1  1-cycle pulse: advance minute by one
//  blink_mask   out  4  digits to blank when blink_on=0; [3:2] hour digits, [1:0] minute digits
//  blink_on     out  1  blink phase; 1 = show all digits
// BEHAVIOUR
//  - Reset (RST=1 at posedge CLK): mode=RUN, hour_inc=min_inc=0, blink_mask=0, blink_on=0, sync flops, debounced
//    levels, all counters cleared. Reset mid-hold: the button must be released and pressed again to register.
//  - Conditioning per button: 2-FF synchronizer -> stability counter. Counter restarts on any change of the
//    synced level vs debounced level; after DEBOUNCE_CYC consecutive differing cycles the debounced level flips.
//    Press event = 1-cycle pulse on the debounced 0->1 edge. Releases produce no event.
//  - FSM, evaluated on press events: RUN -MODE-> SET_HOUR -MODE-> SET_MIN -MODE-> RUN.
//    ADJ press: SET_HOUR -> hour_inc; SET_MIN -> min_inc; RUN -> ignored.
//  - Latency: inc pulse and mode change are registered, visible the cycle after the press-event pulse.
//  - Simultaneous MODE and ADJ press events in one cycle: MODE wins, the ADJ event is discarded.
//  - Inc pulses are never wider than 1 cycle and never both high in the same cycle.
//  - blink_mask: RUN 4'b0000, SET_HOUR 4'b1100, SET_MIN 4'b0011.
//  - blink_on: forced to 1 on entering any SET mode and after each ADJ press; toggles every BLINK_CYC in SET modes;
//    held 0 in RUN.
//  - Timeout: inactivity counter cleared by any press event; when it reaches TIMEOUT_CYC in a SET mode, mode -> RUN
//    the next cycle. A press event in that same cycle is applied and the timeout is discarded.
//  - Counter widths use $clog2 of the max cycle count; no counter may wrap. Counters saturate or reload.
// CONFIGURATION
//  `AUTO_REPEAT_EN defined: ADJ held continuously LONG_CYC after its press event in a SET mode issues one extra inc
//    pulse, then one every REPEAT_CYC until release. Each repeat pulse also clears the timeout and forces blink_on=1.
//    A MODE press while ADJ is held cancels repeat until ADJ is released.
//  `AUTO_REPEAT_EN undefined: exactly one inc pulse per ADJ press. No repeat counter is instantiated.
// STRUCTURE
//  - Shared package clock_pkg: mode encodings MODE_RUN=2'd0, MODE_SET_HOUR=2'd1, MODE_SET_MIN=2'd2;
//    blink mask constants MASK_HOUR=4'b1100, MASK_MIN=4'b0011; ms_to_cyc/s_to_cyc constant functions.
//  - Sub-module btn_conditioner (sync + debounce + press pulse), instantiated twice (MODE, ADJ).
//  - Top: mode FSM, blink timer, inactivity timer, optional repeat timer.
// TESTING (bench: CLK_HZ=1000 so 1 ms = 1 cycle; DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, BLINK_MS=8, TIMEOUT_S=1)
//  1 MODE held high 10 cycles, no bounce -> mode 0->1 exactly 7 cycles after first raw-high edge (2 sync + 4 deb +1);
//    blink_mask=1100, blink_on=1.
//  2 MODE bounce 1,0,1,0 on alternate cycles, then steady 1 -> exactly one mode step; glitch under 4 cycles -> none.
//  3 SET_MIN, ADJ pressed 3 times -> three 1-cycle min_inc pulses, hour_inc never high; in RUN, ADJ press -> no pulse.
//  4 MODE and ADJ raw rise in the same cycle while in SET_HOUR -> mode=2, no hour_inc.
//  5 SET_HOUR, no presses for 1000 cycles -> mode=0 and blink_mask=0; RST asserted mid-SET -> all outputs at reset values
//    next cycle.
//  6 AUTO_REPEAT_EN: SET_HOUR, ADJ held 40 cycles -> 1 press pulse + repeats at +20,+25,+30,+35 (5 total);
//    without the macro -> exactly 1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock-display definitions: mode encodings, digit blink masks and
// elaboration-time helpers converting milliseconds/seconds into clock cycles.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_e;

   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_HOUR = 4'b1100;
   localparam logic [3:0] MASK_MIN  = 4'b0011;

   // Zero-length intervals are clamped to one cycle so every timer stays meaningful.
   function automatic int ms_to_cyc(input longint clk_hz, input longint ms);
      longint c;
      c = (clk_hz * ms) / 64'sd1000;
      return (c < 64'sd1) ? 32'sd1 : int'(c);
   endfunction

   function automatic int s_to_cyc(input longint clk_hz, input longint s);
      longint c;
      c = clk_hz * s;
      return (c < 64'sd1) ? 32'sd1 : int'(c);
   endfunction

   function automatic int cnt_w(input int max_cnt);
      return (max_cnt < 32'sd2) ? 32'sd1 : $clog2(max_cnt + 32'sd1);
   endfunction

   function automatic logic [3:0] mask_of(input mode_e m);
      case (m)
         MODE_SET_HOUR: return MASK_HOUR;
         MODE_SET_MIN:  return MASK_MIN;
         default:       return MASK_NONE;
      endcase
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, stability-counter debounce and a
// registered 1-cycle press pulse on the debounced rising edge.
module btn_conditioner
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_press
);

   localparam int            CW       = cnt_w(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic          r_armed;
   logic [1:0]    r_fill;
   logic [CW-1:0] r_cnt;
   logic          w_flip;

   assign w_flip  = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
   assign o_level = r_level;
   assign o_press = r_press;

   // A button held across reset stays unarmed until the synced level shows a release.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_armed <= 1'b0;
         r_fill  <= 2'b00;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
         if (r_fill[1] && !r_sync2) begin
            r_armed <= 1'b1;
         end
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         r_press <= w_flip && r_sync2 && r_armed;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: debounced MODE/ADJ buttons drive the RUN/SET_HOUR/SET_MIN FSM,
// hour/minute increment pulses, blink mask/phase and inactivity timeout.
// Define AUTO_REPEAT_EN to add auto-repeat while ADJ is held in a SET mode.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ      = 16000000,
   parameter int DEBOUNCE_MS = 10,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200,
   parameter int BLINK_MS    = 500,
   parameter int TIMEOUT_S   = 30
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       btn_mode_raw,
   input  logic       btn_adj_raw,
   output logic [1:0] mode,
   output logic       hour_inc,
   output logic       min_inc,
   output logic [3:0] blink_mask,
   output logic       blink_on
);

   localparam int            DEB_CYC     = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int            BLINK_CYC   = ms_to_cyc(CLK_HZ, BLINK_MS);
   localparam int            TIMEOUT_CYC = s_to_cyc(CLK_HZ, TIMEOUT_S);
   localparam int            BW          = cnt_w(BLINK_CYC);
   localparam int            IW          = cnt_w(TIMEOUT_CYC);
   localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYC - 1);
   localparam logic [BW-1:0] BLINK_ONE   = BW'(32'd1);
   localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT_CYC);
   localparam logic [IW-1:0] IDLE_ONE    = IW'(32'd1);

   mode_e         r_mode;
   logic          r_hour_inc;
   logic          r_min_inc;
   logic [3:0]    r_blink_mask;
   logic          r_blink_on;
   logic [BW-1:0] r_blink_cnt;
   logic [IW-1:0] r_idle_cnt;

   mode_e         w_mode_nxt;
   logic          w_hour_nxt;
   logic          w_min_nxt;
   logic          w_blink_force;
   logic          w_mode_press;
   logic          w_adj_press;
   logic          w_adj_level;
   logic          w_mode_level_unused;
   logic          w_rep_pulse;
   logic          w_adj_evt;
   logic          w_any_evt;
   logic          w_timeout;

   btn_conditioner #(.DEBOUNCE_CYC(DEB_CYC)) u_mode_btn (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_raw   (btn_mode_raw),
      .o_level (w_mode_level_unused),
      .o_press (w_mode_press)
   );

   btn_conditioner #(.DEBOUNCE_CYC(DEB_CYC)) u_adj_btn (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_raw   (btn_adj_raw),
      .o_level (w_adj_level),
      .o_press (w_adj_press)
   );

`ifdef AUTO_REPEAT_EN
   localparam int            LONG_CYC   = ms_to_cyc(CLK_HZ, LONG_MS);
   localparam int            REPEAT_CYC = ms_to_cyc(CLK_HZ, REPEAT_MS);
   localparam int            RW         = cnt_w((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC);
   localparam logic [RW-1:0] LONG_LAST  = RW'(LONG_CYC - 1);
   localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYC - 1);
   localparam logic [RW-1:0] REP_ONE    = RW'(32'd1);

   logic          r_rep_active;
   logic          r_rep_phase;
   logic [RW-1:0] r_rep_cnt;

   assign w_rep_pulse = r_rep_active && w_adj_level && (r_mode != MODE_RUN) &&
                        (r_rep_cnt == (r_rep_phase ? REP_LAST : LONG_LAST));

   // Repeat timer: first interval LONG, then REPEAT; cancelled by MODE press, release or RUN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rep_active <= 1'b0;
         r_rep_phase  <= 1'b0;
         r_rep_cnt    <= '0;
      end else if (w_mode_press || !w_adj_level || (r_mode == MODE_RUN)) begin
         r_rep_active <= 1'b0;
         r_rep_phase  <= 1'b0;
         r_rep_cnt    <= '0;
      end else if (w_adj_press) begin
         r_rep_active <= 1'b1;
         r_rep_phase  <= 1'b0;
         r_rep_cnt    <= '0;
      end else if (w_rep_pulse) begin
         r_rep_phase <= 1'b1;
         r_rep_cnt   <= '0;
      end else if (r_rep_active) begin
         r_rep_cnt <= r_rep_cnt + REP_ONE;
      end
   end
`else
   logic w_adj_level_unused;

   assign w_adj_level_unused = w_adj_level;
   assign w_rep_pulse        = 1'b0;
`endif

   assign w_adj_evt = w_adj_press | w_rep_pulse;
   assign w_any_evt = w_mode_press | w_adj_press | w_rep_pulse;
   assign w_timeout = (r_mode != MODE_RUN) && (r_idle_cnt == IDLE_MAX);

   // Next mode and pulse decode; MODE beats ADJ, and any event beats the timeout.
   always_comb begin
      w_mode_nxt    = r_mode;
      w_hour_nxt    = 1'b0;
      w_min_nxt     = 1'b0;
      w_blink_force = 1'b0;
      if (w_mode_press) begin
         w_blink_force = 1'b1;
         case (r_mode)
            MODE_RUN:      w_mode_nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: w_mode_nxt = MODE_SET_MIN;
            MODE_SET_MIN:  w_mode_nxt = MODE_RUN;
            default:       w_mode_nxt = MODE_RUN;
         endcase
      end else if (w_adj_evt) begin
         case (r_mode)
            MODE_SET_HOUR: begin
               w_hour_nxt    = 1'b1;
               w_blink_force = 1'b1;
            end
            MODE_SET_MIN: begin
               w_min_nxt     = 1'b1;
               w_blink_force = 1'b1;
            end
            default: w_blink_force = 1'b0;
         endcase
      end else if (w_timeout) begin
         w_mode_nxt = MODE_RUN;
      end else begin
         w_mode_nxt = r_mode;
      end
   end

   // Registered outputs, blink phase timer and saturating inactivity counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_mode       <= MODE_RUN;
         r_hour_inc   <= 1'b0;
         r_min_inc    <= 1'b0;
         r_blink_mask <= MASK_NONE;
         r_blink_on   <= 1'b0;
         r_blink_cnt  <= '0;
         r_idle_cnt   <= '0;
      end else begin
         r_mode       <= w_mode_nxt;
         r_hour_inc   <= w_hour_nxt;
         r_min_inc    <= w_min_nxt;
         r_blink_mask <= mask_of(w_mode_nxt);
         if (w_mode_nxt == MODE_RUN) begin
            r_blink_on  <= 1'b0;
            r_blink_cnt <= '0;
         end else if (w_blink_force) begin
            r_blink_on  <= 1'b1;
            r_blink_cnt <= '0;
         end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_on  <= ~r_blink_on;
            r_blink_cnt <= '0;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
         end
         if (w_any_evt || (r_mode == MODE_RUN)) begin
            r_idle_cnt <= '0;
         end else if (r_idle_cnt != IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + IDLE_ONE;
         end
      end
   end

   assign mode       = r_mode;
   assign hour_inc   = r_hour_inc;
   assign min_inc    = r_min_inc;
   assign blink_mask = r_blink_mask;
   assign blink_on   = r_blink_on;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl at CLK_HZ=1000 (1 ms = 1 cycle).
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_mode_raw = 1'b0;
   logic       btn_adj_raw = 1'b0;
   logic [1:0] mode;
   logic       hour_inc;
   logic       min_inc;
   logic [3:0] blink_mask;
   logic       blink_on;

   int checks = 0;
   int fails = 0;
   int hour_cnt = 0;
   int min_cnt = 0;
   int wide_cnt = 0;
   int both_cnt = 0;
   logic prev_h = 1'b0;
   logic prev_m = 1'b0;

   time_set_ctrl #(
      .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .BLINK_MS(8), .TIMEOUT_S(1)
   ) dut (
      .CLK(clk), .RST(rst), .btn_mode_raw(btn_mode_raw), .btn_adj_raw(btn_adj_raw),
      .mode(mode), .hour_inc(hour_inc), .min_inc(min_inc), .blink_mask(blink_mask), .blink_on(blink_on)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (hour_inc === 1'b1) hour_cnt++;
      if (min_inc === 1'b1) min_cnt++;
      if ((hour_inc === 1'b1 && prev_h) || (min_inc === 1'b1 && prev_m)) wide_cnt++;
      if (hour_inc === 1'b1 && min_inc === 1'b1) both_cnt++;
      prev_h = (hour_inc === 1'b1);
      prev_m = (min_inc === 1'b1);
   endtask

   task automatic clear_counts();
      hour_cnt = 0;
      min_cnt = 0;
      wide_cnt = 0;
      both_cnt = 0;
   endtask

   task automatic press(input logic m, input logic a, input int hold);
      btn_mode_raw = m;
      btn_adj_raw = a;
      repeat (hold) tick();
      btn_mode_raw = 1'b0;
      btn_adj_raw = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks++; if (mode !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d expected 0", mode); end
      checks++; if (hour_inc !== 1'b0 || min_inc !== 1'b0) begin fails++; $display("FAIL reset_inc: got %b%b expected 00", hour_inc, min_inc); end
      checks++; if (blink_mask !== 4'b0000) begin fails++; $display("FAIL reset_mask: got %b expected 0000", blink_mask); end
      checks++; if (blink_on !== 1'b0) begin fails++; $display("FAIL reset_blink_on: got %b expected 0", blink_on); end
      repeat (5) tick();
   endtask

   task automatic test_mode_press();
      btn_mode_raw = 1'b1;
      repeat (6) tick();
      checks++; if (mode !== 2'd0) begin fails++; $display("FAIL latency_early: got %0d expected 0", mode); end
      tick();
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL latency_mode: got %0d expected 1", mode); end
      checks++; if (blink_mask !== 4'b1100) begin fails++; $display("FAIL set_hour_mask: got %b expected 1100", blink_mask); end
      checks++; if (blink_on !== 1'b1) begin fails++; $display("FAIL set_hour_blink_on: got %b expected 1", blink_on); end
      repeat (3) tick();
      btn_mode_raw = 1'b0;
      repeat (12) tick();
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL hold_single_step: got %0d expected 1", mode); end
   endtask

   task automatic test_bounce();
      press(1'b1, 1'b0, 3);
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL short_glitch: got %0d expected 1", mode); end
      btn_mode_raw = 1'b1; tick();
      btn_mode_raw = 1'b0; tick();
      btn_mode_raw = 1'b1; tick();
      btn_mode_raw = 1'b0; tick();
      press(1'b1, 1'b0, 10);
      checks++; if (mode !== 2'd2) begin fails++; $display("FAIL bounce_one_step: got %0d expected 2", mode); end
      checks++; if (blink_mask !== 4'b0011) begin fails++; $display("FAIL set_min_mask: got %b expected 0011", blink_mask); end
   endtask

   task automatic test_adj_min();
      clear_counts();
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 6);
      checks++; if (min_cnt !== 3) begin fails++; $display("FAIL min_inc_count: got %0d expected 3", min_cnt); end
      checks++; if (hour_cnt !== 0) begin fails++; $display("FAIL hour_inc_in_min: got %0d expected 0", hour_cnt); end
      checks++; if (wide_cnt !== 0 || both_cnt !== 0) begin fails++; $display("FAIL pulse_shape: got wide=%0d both=%0d expected 0 0", wide_cnt, both_cnt); end
      checks++; if (mode !== 2'd2) begin fails++; $display("FAIL adj_keeps_mode: got %0d expected 2", mode); end
      press(1'b1, 1'b0, 6);
      checks++; if (mode !== 2'd0) begin fails++; $display("FAIL wrap_to_run: got %0d expected 0", mode); end
      clear_counts();
      press(1'b0, 1'b1, 6);
      checks++; if (hour_cnt !== 0 || min_cnt !== 0) begin fails++; $display("FAIL adj_in_run: got h=%0d m=%0d expected 0 0", hour_cnt, min_cnt); end
   endtask

   task automatic test_simultaneous();
      press(1'b1, 1'b0, 6);
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL enter_set_hour: got %0d expected 1", mode); end
      clear_counts();
      press(1'b1, 1'b1, 6);
      checks++; if (mode !== 2'd2) begin fails++; $display("FAIL simul_mode: got %0d expected 2", mode); end
      checks++; if (hour_cnt !== 0 || min_cnt !== 0) begin fails++; $display("FAIL simul_no_inc: got h=%0d m=%0d expected 0 0", hour_cnt, min_cnt); end
   endtask

   task automatic test_timeout();
      bit seen;
      press(1'b1, 1'b0, 6);
      checks++; if (mode !== 2'd0) begin fails++; $display("FAIL back_to_run: got %0d expected 0", mode); end
      seen = 1'b0;
      btn_mode_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mode === 2'd1) begin
            seen = 1'b1;
            break;
         end
      end
      btn_mode_raw = 1'b0;
      checks++; if (seen !== 1'b1) begin fails++; $display("FAIL timeout_entry: got mode %0d expected 1 within 20 cycles", mode); end
      repeat (7) tick();
      checks++; if (blink_on !== 1'b1) begin fails++; $display("FAIL blink_phase_hi: got %b expected 1", blink_on); end
      tick();
      checks++; if (blink_on !== 1'b0) begin fails++; $display("FAIL blink_toggle: got %b expected 0", blink_on); end
      repeat (986) tick();
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL timeout_early: got %0d expected 1", mode); end
      repeat (10) tick();
      checks++; if (mode !== 2'd0) begin fails++; $display("FAIL timeout_mode: got %0d expected 0", mode); end
      checks++; if (blink_mask !== 4'b0000 || blink_on !== 1'b0) begin fails++; $display("FAIL timeout_blink: got %b/%b expected 0000/0", blink_mask, blink_on); end
   endtask

   task automatic test_reset_mid_set();
      press(1'b1, 1'b0, 6);
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL pre_reset_mode: got %0d expected 1", mode); end
      rst = 1'b1;
      tick();
      checks++; if (mode !== 2'd0 || blink_mask !== 4'b0000 || blink_on !== 1'b0 || hour_inc !== 1'b0 || min_inc !== 1'b0) begin
         fails++; $display("FAIL reset_mid_set: got mode=%0d mask=%b on=%b inc=%b%b expected 0 0000 0 00", mode, blink_mask, blink_on, hour_inc, min_inc);
      end
      btn_mode_raw = 1'b1;
      tick();
      rst = 1'b0;
      repeat (20) tick();
      checks++; if (mode !== 2'd0) begin fails++; $display("FAIL held_through_reset: got %0d expected 0", mode); end
      btn_mode_raw = 1'b0;
      repeat (12) tick();
      press(1'b1, 1'b0, 6);
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL repress_after_reset: got %0d expected 1", mode); end
   endtask

   task automatic test_auto_repeat();
      int exp_h;
`ifdef AUTO_REPEAT_EN
      exp_h = 5;
`else
      exp_h = 1;
`endif
      clear_counts();
      btn_adj_raw = 1'b1;
      repeat (40) tick();
      btn_adj_raw = 1'b0;
      repeat (20) tick();
      checks++; if (hour_cnt !== exp_h) begin fails++; $display("FAIL repeat_count: got %0d expected %0d", hour_cnt, exp_h); end
      checks++; if (min_cnt !== 0 || wide_cnt !== 0 || both_cnt !== 0) begin fails++; $display("FAIL repeat_shape: got m=%0d wide=%0d both=%0d expected 0 0 0", min_cnt, wide_cnt, both_cnt); end
      checks++; if (mode !== 2'd1) begin fails++; $display("FAIL repeat_mode: got %0d expected 1", mode); end
   endtask

   initial begin
      test_reset();
      test_mode_press();
      test_bounce();
      test_adj_min();
      test_simultaneous();
      test_timeout();
      test_reset_mid_set();
      test_auto_repeat();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
